traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000; clock cycles per 1 s tick.
REQ-002 Parameter GREEN_S, default 10; GREEN phase length in seconds.
REQ-003 Parameter YELLOW_S, default 3; YELLOW phase length in seconds.
REQ-004 Parameter RED_S, default 8; RED phase length in seconds.
REQ-005 Parameter GREEN_MIN_S, default 4; minimum GREEN length when a pedestrian request truncates GREEN.
REQ-006 Port CLOCK_50 input, 1 bit: sole clock; all logic on rising edge.
REQ-007 Port KEY input, 1 bit: synchronous, active-high reset.
REQ-008 Port ped_req input, 1 bit: pedestrian request level, sampled every clock.
REQ-009 Port state output, 3 bits: phase code for the 4-digit display decoder; GREEN=000, YELLOW=011, RED=010.
REQ-010 Port light output, 3 bits: one-hot lamps {red,yellow,green}.
REQ-011 Port remain output, 8 bits: whole seconds left in the current phase.
REQ-012 Port tick output, 1 bit: one-cycle pulse at each 1 s boundary.
REQ-013 Port ped_walk output, 1 bit: walk lamp.

Function
REQ-014 Prescaler counts 0..CLK_HZ-1 and wraps to 0; tick=1 for exactly the cycle in which the count equals CLK_HZ-1.
REQ-015 FSM has exactly three states (RED, GREEN, YELLOW); sequence RED->GREEN->YELLOW->RED; codes 001, 100, 101, 110 and 111 never appear on state.
REQ-016 On phase entry, remain loads that phase's duration parameter.
REQ-017 On tick with remain>1, remain decrements by 1; on tick with remain==1, FSM advances and remain loads the next phase's duration in the same cycle.
REQ-018 light is 100 in RED, 001 in GREEN, 010 in YELLOW; it changes in the same cycle as state.
REQ-019 All outputs are registered; no combinational path from ped_req to any output.
REQ-020 Durations are 1..255; GREEN_MIN_S<=GREEN_S; other values are unsupported.
REQ-021 Total period = RED_S+GREEN_S+YELLOW_S ticks when no pedestrian request is active.

Reset
REQ-022 KEY=1 at a rising edge forces state=010, light=100, remain=RED_S, prescaler=0, tick=0, ped_walk=0, and pending request cleared.
REQ-023 Reset overrides every other event in the same cycle, including mid-phase, mid-truncation and a coincident tick.
REQ-024 The first tick after reset release occurs CLK_HZ cycles after the last reset cycle.

Configuration
REQ-025 Macro TRAFFIC_PED_REQ_EN defined: pedestrian logic is compiled in (REQ-026..REQ-029).
REQ-026 With the macro, ped_req=1 sets an internal pending flag in any phase; the flag clears on entry to RED.
REQ-027 With the macro, in GREEN while pending=1 and remain>GREEN_MIN_S, remain loads GREEN_MIN_S on the next cycle; truncation has priority over a coincident tick, and that tick does not decrement.
REQ-028 With the macro, a request while remain<=GREEN_MIN_S, or during YELLOW, leaves the timing unchanged and is served at the next RED entry.
REQ-029 With the macro, ped_walk=1 for the whole RED phase entered with pending=1, and 0 otherwise.
REQ-030 Without the macro, ped_req is ignored, ped_walk is tied to 0, and timing follows REQ-017 only.

Verification (CLK_HZ=4, other parameters default)
REQ-031 Hold KEY=1 for 2 cycles, then release -> state=010, light=100, remain=8, ped_walk=0; first tick 4 cycles after release.
REQ-032 Free run with ped_req=0 -> RED for 8 ticks, then 000/remain=10 for 10 ticks, then 011/remain=3 for 3 ticks, then 010; period is 84 cycles.
REQ-033 Macro on, ped_req pulse in GREEN at remain=9 -> remain=4 the next cycle, YELLOW 4 ticks later, then RED with ped_walk=1 and pending cleared.
REQ-034 Macro on, ped_req in GREEN at remain=3 -> remain is unaffected, GREEN ends normally, and ped_walk=1 in the following RED.
REQ-035 KEY=1 mid-YELLOW at remain=2 with pending=1 -> next cycle state=010, remain=8, ped_walk=0, prescaler=0.
REQ-036 Macro off, ped_req toggled throughout a full period -> timing identical to REQ-032, and ped_walk stays 0.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Purpose:
//   Single-intersection traffic light sequencer. A free-running prescaler
//   divides CLOCK_50 down to a 1 s tick. A three-phase FSM steps
//   RED -> GREEN -> YELLOW -> RED, counting each phase down in whole seconds.
//   An optional pedestrian feature can cut GREEN short and lights a walk lamp
//   for the RED phase that serves the request.
//
// Configuration macro:
//   TRAFFIC_PED_REQ_EN  defined   : pedestrian request / walk logic built in.
//                       undefined : ped_req ignored, ped_walk held at 0.
//
// Parameters:
//   CLK_HZ       clock cycles per 1 s tick
//   GREEN_S      GREEN length in seconds   (1..255)
//   YELLOW_S     YELLOW length in seconds  (1..255)
//   RED_S        RED length in seconds     (1..255)
//   GREEN_MIN_S  GREEN length left after a pedestrian truncation (<= GREEN_S)
//
// Ports:
//   CLOCK_50   in   1  sole clock, rising edge
//   KEY        in   1  synchronous active-high reset
//   ped_req    in   1  pedestrian request level, sampled every clock
//   state      out  3  phase code: GREEN=000, YELLOW=011, RED=010
//   light      out  3  one-hot lamps {red,yellow,green}
//   remain     out  8  whole seconds left in the current phase
//   tick       out  1  one-cycle pulse on each 1 s boundary
//   ped_walk   out  1  walk lamp
//
// Every output comes straight from a flop; ped_req only reaches outputs
// through registered state.
// -----------------------------------------------------------------------------
module traffic_phase_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GREEN_S     = 10,
  parameter int YELLOW_S    = 3,
  parameter int RED_S       = 8,
  parameter int GREEN_MIN_S = 4
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       ped_req,
  output logic [2:0] state,
  output logic [2:0] light,
  output logic [7:0] remain,
  output logic       tick,
  output logic       ped_walk
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // Phase codes double as the display-decoder codes, so the state register
  // can drive the state port directly.
  typedef enum logic [2:0] {
    ST_GREEN  = 3'b000,
    ST_RED    = 3'b010,
    ST_YELLOW = 3'b011
  } phase_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  localparam logic [7:0] GREEN_LEN     = 8'(GREEN_S);
  localparam logic [7:0] YELLOW_LEN    = 8'(YELLOW_S);
  localparam logic [7:0] RED_LEN       = 8'(RED_S);
  localparam logic [7:0] GREEN_MIN_LEN = 8'(GREEN_MIN_S);

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_tick;

  phase_e        r_state;
  phase_e        w_state_next;
  logic [7:0]    r_remain;
  logic [7:0]    w_remain_next;
  logic [2:0]    r_light;
  logic [2:0]    w_light_next;
  logic          r_walk;
  logic          w_walk_next;

  logic          w_red_entry;   // this cycle's update moves the FSM into RED
  logic          w_ped_eff;     // request seen now or remembered from earlier
  logic          w_truncate;    // GREEN is cut down to GREEN_MIN_S this cycle

  // ---------------------------------------------------------------------------
  // 1 s prescaler
  // ---------------------------------------------------------------------------
  always_comb begin
    w_presc_next = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
  end

  // tick is registered from the *next* count so that it is high in exactly
  // the cycle where r_presc sits at CLK_HZ-1.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_next;
      r_tick  <= (w_presc_next == PRESC_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Pedestrian request
  // ---------------------------------------------------------------------------
`ifdef TRAFFIC_PED_REQ_EN
  logic r_pending;

  // A request acts in the same cycle it is sampled, and is remembered until
  // the next RED entry serves it.
  assign w_ped_eff  = r_pending | ped_req;
  assign w_truncate = (r_state == ST_GREEN) && w_ped_eff &&
                      (r_remain > GREEN_MIN_LEN);

  // The RED entry consumes the request, including one arriving in that very
  // cycle; anything later waits for the following RED.
  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      r_pending <= 1'b0;
    end else if (w_red_entry) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_ped_eff;
    end
  end
`else
  logic w_ped_req_unused;

  assign w_ped_req_unused = ped_req;
  assign w_ped_eff        = 1'b0;
  assign w_truncate       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      r_state  <= ST_RED;
      r_remain <= RED_LEN;
      r_light  <= LAMP_RED;
      r_walk   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_remain <= w_remain_next;
      r_light  <= w_light_next;
      r_walk   <= w_walk_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Truncation wins over a coincident tick: the countdown restarts at
  // GREEN_MIN_S and that tick is not also taken off.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_state_next  = r_state;
    w_remain_next = r_remain;
    if (w_truncate) begin
      w_remain_next = GREEN_MIN_LEN;
    end else if (r_tick) begin
      if (r_remain > 8'd1) begin
        w_remain_next = r_remain - 8'd1;
      end else begin
        case (r_state)
          ST_RED: begin
            w_state_next  = ST_GREEN;
            w_remain_next = GREEN_LEN;
          end
          ST_GREEN: begin
            w_state_next  = ST_YELLOW;
            w_remain_next = YELLOW_LEN;
          end
          ST_YELLOW: begin
            w_state_next  = ST_RED;
            w_remain_next = RED_LEN;
          end
          default: begin
            w_state_next  = ST_RED;
            w_remain_next = RED_LEN;
          end
        endcase
      end
    end
  end

  assign w_red_entry = (w_state_next == ST_RED) && (r_state != ST_RED);

  // ---------------------------------------------------------------------------
  // FSM: output logic (computed from the next state, then registered so the
  // lamps change in the same cycle as the state code)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_light_next = LAMP_RED;
    w_walk_next  = 1'b0;
    case (w_state_next)
      ST_GREEN:  w_light_next = LAMP_GREEN;
      ST_YELLOW: w_light_next = LAMP_YELLOW;
      default:   w_light_next = LAMP_RED;
    endcase
    // The walk lamp is decided once at RED entry and held for the whole RED.
    if (w_red_entry) begin
      w_walk_next = w_ped_eff;
    end else if (w_state_next == ST_RED) begin
      w_walk_next = r_walk;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign state    = r_state;
  assign light    = r_light;
  assign remain   = r_remain;
  assign tick     = r_tick;
  assign ped_walk = r_walk;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_ctrl
//
// Directed bench for traffic_phase_ctrl with CLK_HZ=4. The stimulus thread
// walks a fixed timeline; p counts clock periods after the last reset edge
// (p=0 is the first cycle with KEY released). At chosen periods it pushes the
// hand-derived expected outputs into a scoreboard queue tagged with the cycle
// they belong to; a monitor samples the DUT on the falling edge and checks
// each entry in its cycle.
//
// Timeline with defaults (RED 8, GREEN 10, YELLOW 3, 4 cycles/tick):
//   RED 0..31, GREEN 32..71, YELLOW 72..83, RED again at 84 (period 84).
//   Ticks fall in periods where p mod 4 == 3.
// Build with +define+TRAFFIC_PED_REQ_EN to exercise the pedestrian scenarios;
// without it ped_req toggles every cycle and timing must stay free-running.
// -----------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

  localparam int CLK_HZ = 4;

  localparam logic [2:0] S_GREEN  = 3'b000;
  localparam logic [2:0] S_YELLOW = 3'b011;
  localparam logic [2:0] S_RED    = 3'b010;

  logic       clk = 1'b0;
  logic       key;
  logic       ped_req;
  logic [2:0] state;
  logic [2:0] light;
  logic [7:0] remain;
  logic       tick;
  logic       ped_walk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [2:0]  st;
    logic [7:0]  rem;
    logic        tk;
    logic        walk;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cur_p = 0;
  bit          toggle_en = 1'b0;

  traffic_phase_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .GREEN_S     (10),
    .YELLOW_S    (3),
    .RED_S       (8),
    .GREEN_MIN_S (4)
  ) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .ped_req  (ped_req),
    .state    (state),
    .light    (light),
    .remain   (remain),
    .tick     (tick),
    .ped_walk (ped_walk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Lamp pattern each phase must show.
  function automatic logic [2:0] lamp_of(input logic [2:0] st);
    case (st)
      S_GREEN:  return 3'b001;
      S_YELLOW: return 3'b010;
      default:  return 3'b100;
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [2:0] want_light;
    want_light = lamp_of(e.st);
    n_tests++;
    if (state !== e.st || light !== want_light || remain !== e.rem ||
        tick !== e.tk || ped_walk !== e.walk) begin
      n_fail++;
      $display("FAIL %s: got state=%b light=%b remain=%0d tick=%b walk=%b, want state=%b light=%b remain=%0d tick=%b walk=%b",
               e.name, state, light, remain, tick, ped_walk,
               e.st, want_light, e.rem, e.tk, e.walk);
    end
  endtask

  // Monitor: compares every scoreboard entry in the cycle it was tagged with.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: entry for cycle %0d not checked until cycle %0d",
                 e.name, e.cyc, cyc);
      end else begin
        check(e);
      end
    end
  end

  // Advance n periods; inputs change 1 time unit after the rising edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cur_p++;
      if (toggle_en) ped_req = ~ped_req;
    end
  endtask

  task automatic go(input int p);
    if (p > cur_p) adv(p - cur_p);
  endtask

  task automatic expect_now(input string name, input logic [2:0] st,
                            input logic [7:0] rem, input logic tk,
                            input logic walk);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.st   = st;
    e.rem  = rem;
    e.tk   = tk;
    e.walk = walk;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key     = 1'b1;
    ped_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cur_p = 0;
    key   = 1'b0;
`ifndef TRAFFIC_PED_REQ_EN
    toggle_en = 1'b1;
`endif

    // Reset state and free-running sequence.
    expect_now("reset_release",   S_RED,    8,  1'b0, 1'b0);
    go(2);  expect_now("before_first_tick", S_RED, 8, 1'b0, 1'b0);
    go(3);  expect_now("first_tick",        S_RED, 8, 1'b1, 1'b0);
    go(4);  expect_now("red_decrement",     S_RED, 7, 1'b0, 1'b0);
    go(31); expect_now("red_last_tick",     S_RED, 1, 1'b1, 1'b0);
    go(32); expect_now("green_entry",     S_GREEN, 10, 1'b0, 1'b0);
    go(35); expect_now("green_first_tick", S_GREEN, 10, 1'b1, 1'b0);
    go(36); expect_now("green_decrement", S_GREEN, 9,  1'b0, 1'b0);
    go(71); expect_now("green_last_tick", S_GREEN, 1,  1'b1, 1'b0);
    go(72); expect_now("yellow_entry",   S_YELLOW, 3,  1'b0, 1'b0);
    go(83); expect_now("yellow_last_tick", S_YELLOW, 1, 1'b1, 1'b0);
    go(84); expect_now("period_wrap",       S_RED, 8, 1'b0, 1'b0);
    go(87); expect_now("period_wrap_tick",  S_RED, 8, 1'b1, 1'b0);

`ifdef TRAFFIC_PED_REQ_EN
    // Request at remain=9 cuts GREEN to 4 s.
    go(120); expect_now("green9_before_req", S_GREEN, 9, 1'b0, 1'b0);
    ped_req = 1'b1;
    go(121); ped_req = 1'b0;
    expect_now("truncate_to_min",   S_GREEN, 4, 1'b0, 1'b0);
    go(123); expect_now("trunc_tick",        S_GREEN, 4, 1'b1, 1'b0);
    go(124); expect_now("trunc_decrement",   S_GREEN, 3, 1'b0, 1'b0);
    go(135); expect_now("trunc_last_tick",   S_GREEN, 1, 1'b1, 1'b0);
    go(136); expect_now("trunc_yellow",     S_YELLOW, 3, 1'b0, 1'b0);
    go(148); expect_now("walk_red_entry",      S_RED, 8, 1'b0, 1'b1);
    go(175); expect_now("walk_held_in_red",    S_RED, 2, 1'b1, 1'b1);
    go(180); expect_now("walk_off_green",    S_GREEN, 10, 1'b0, 1'b0);

    // Request at remain=3 leaves GREEN alone but is served at next RED.
    go(208); expect_now("green3_before_req", S_GREEN, 3, 1'b0, 1'b0);
    ped_req = 1'b1;
    go(209); ped_req = 1'b0;
    expect_now("late_req_no_trunc", S_GREEN, 3, 1'b0, 1'b0);
    go(211); expect_now("late_req_tick",     S_GREEN, 3, 1'b1, 1'b0);
    go(220); expect_now("late_req_yellow",  S_YELLOW, 3, 1'b0, 1'b0);
    go(232); expect_now("late_req_walk",       S_RED, 8, 1'b0, 1'b1);
    go(264); expect_now("pending_consumed",  S_GREEN, 10, 1'b0, 1'b0);

    // Request during YELLOW, then reset on a tick at remain=2.
    go(304); expect_now("yellow_before_req", S_YELLOW, 3, 1'b0, 1'b0);
    ped_req = 1'b1;
    go(305); ped_req = 1'b0;
    expect_now("yellow_req_no_effect", S_YELLOW, 3, 1'b0, 1'b0);
    go(311); expect_now("yellow2_tick",     S_YELLOW, 2, 1'b1, 1'b0);
    key = 1'b1;
    go(312); key = 1'b0;
    expect_now("reset_mid_yellow",     S_RED, 8, 1'b0, 1'b0);
    go(315); expect_now("reset_first_tick", S_RED, 8, 1'b1, 1'b0);
    go(316); expect_now("reset_decrement",  S_RED, 7, 1'b0, 1'b0);
    go(348); expect_now("pending_cleared_by_reset", S_GREEN, 9, 1'b0, 1'b0);
`else
    // ped_req keeps toggling: timing must match the free-running schedule.
    go(120); expect_now("ign_green9",        S_GREEN, 9, 1'b0, 1'b0);
    go(123); expect_now("ign_green9_tick",   S_GREEN, 9, 1'b1, 1'b0);
    go(124); expect_now("ign_green8",        S_GREEN, 8, 1'b0, 1'b0);
    go(156); expect_now("ign_yellow",       S_YELLOW, 3, 1'b0, 1'b0);
    go(168); expect_now("ign_red_no_walk",     S_RED, 8, 1'b0, 1'b0);
    go(252); expect_now("ign_third_period",    S_RED, 8, 1'b0, 1'b0);
    go(324); expect_now("ign_yellow3",      S_YELLOW, 3, 1'b0, 1'b0);
    go(331); expect_now("yellow2_tick",     S_YELLOW, 2, 1'b1, 1'b0);
    key = 1'b1;
    go(332); key = 1'b0;
    expect_now("reset_mid_yellow",     S_RED, 8, 1'b0, 1'b0);
    go(335); expect_now("reset_first_tick", S_RED, 8, 1'b1, 1'b0);
    go(336); expect_now("reset_decrement",  S_RED, 7, 1'b0, 1'b0);
`endif

    toggle_en = 1'b0;
    adv(3);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
